// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: coordinates, strobes, pipelined sync/de.
// Optional completed-frame counter enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int HS_POL    = 0,
   parameter int VS_POL    = 0,
   parameter int CW        = 10,
   parameter int PIPE      = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          active,
   output logic          line_start,
   output logic          frame_start,
   output logic          vblank_start,
   output logic          de,
   output logic          hs,
   output logic          vs,
   output logic [15:0]   frame_count
);

   localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VISIBLE + H_FP;
   localparam int VS_START = V_VISIBLE + V_FP;

   // One extra bit so sync end bounds equal to the total never truncate.
   localparam logic [CW:0] H_LAST_C     = (CW+1)'(H_TOTAL - 1);
   localparam logic [CW:0] V_LAST_C     = (CW+1)'(V_TOTAL - 1);
   localparam logic [CW:0] H_VIS_C      = (CW+1)'(H_VISIBLE);
   localparam logic [CW:0] V_VIS_C      = (CW+1)'(V_VISIBLE);
   localparam logic [CW:0] HS_START_C   = (CW+1)'(HS_START);
   localparam logic [CW:0] HS_END_C     = (CW+1)'(HS_START + H_SYNC);
   localparam logic [CW:0] VS_START_C   = (CW+1)'(VS_START);
   localparam logic [CW:0] VS_END_C     = (CW+1)'(VS_START + V_SYNC);
   localparam logic [CW-1:0] ZERO_C     = CW'(0);
   localparam logic [CW-1:0] ONE_C      = CW'(1);
   localparam logic        HS_ACT_C     = (HS_POL != 0) ? 1'b1 : 1'b0;
   localparam logic        VS_ACT_C     = (VS_POL != 0) ? 1'b1 : 1'b0;

   if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_cw_overflow
      $error("vga_timing_gen: CW=%0d too narrow for H_TOTAL=%0d / V_TOTAL=%0d", CW, H_TOTAL, V_TOTAL);
   end
   if ((PIPE < 0) || (PIPE > 8)) begin : g_pipe_range
      $error("vga_timing_gen: PIPE=%0d outside 0..8", PIPE);
   end

   logic [CW-1:0] x_r;
   logic [CW-1:0] y_r;
   logic [CW:0]   x_ext_s;
   logic [CW:0]   y_ext_s;
   logic          x_last_s;
   logic          y_last_s;
   logic          active_s;
   logic          raw_hs_s;
   logic          raw_vs_s;
   logic          strobe_en_s;
   logic          de_d_s;
   logic          hs_d_s;
   logic          vs_d_s;

   assign x_ext_s  = {1'b0, x_r};
   assign y_ext_s  = {1'b0, y_r};
   assign x_last_s = (x_ext_s == H_LAST_C);
   assign y_last_s = (y_ext_s == V_LAST_C);

   // Raster counters: x every pixel enable, y on the last pixel of each line.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r <= ZERO_C;
         y_r <= ZERO_C;
      end else if (ce) begin
         if (x_last_s) begin
            x_r <= ZERO_C;
            if (y_last_s) begin
               y_r <= ZERO_C;
            end else begin
               y_r <= y_r + ONE_C;
            end
         end else begin
            x_r <= x_r + ONE_C;
         end
      end
   end

   assign active_s = (x_ext_s < H_VIS_C) && (y_ext_s < V_VIS_C);
   assign raw_hs_s = (x_ext_s >= HS_START_C) && (x_ext_s < HS_END_C);
   assign raw_vs_s = (y_ext_s >= VS_START_C) && (y_ext_s < VS_END_C);

   // Strobes are suppressed while reset is held so no partial-frame tick escapes.
   assign strobe_en_s  = ce & ~rst;
   assign line_start   = strobe_en_s && (x_r == ZERO_C);
   assign frame_start  = line_start && (y_r == ZERO_C);
   assign vblank_start = line_start && (y_ext_s == V_VIS_C);

   if (PIPE == 0) begin : g_nopipe
      assign de_d_s = active_s;
      assign hs_d_s = raw_hs_s;
      assign vs_d_s = raw_vs_s;
   end else begin : g_pipe
      logic [PIPE-1:0] de_pipe_r;
      logic [PIPE-1:0] hs_pipe_r;
      logic [PIPE-1:0] vs_pipe_r;

      // Delay line shifting once per pixel enable; bit 0 is the newest sample.
      always_ff @(posedge clk) begin
         if (rst) begin
            de_pipe_r <= PIPE'(0);
            hs_pipe_r <= PIPE'(0);
            vs_pipe_r <= PIPE'(0);
         end else if (ce) begin
            de_pipe_r <= (de_pipe_r << 1) | PIPE'(active_s);
            hs_pipe_r <= (hs_pipe_r << 1) | PIPE'(raw_hs_s);
            vs_pipe_r <= (vs_pipe_r << 1) | PIPE'(raw_vs_s);
         end
      end

      assign de_d_s = de_pipe_r[PIPE-1];
      assign hs_d_s = hs_pipe_r[PIPE-1];
      assign vs_d_s = vs_pipe_r[PIPE-1];
   end

   assign x      = x_r;
   assign y      = y_r;
   assign active = active_s;
   assign de     = de_d_s;
   assign hs     = hs_d_s ? HS_ACT_C : ~HS_ACT_C;
   assign vs     = vs_d_s ? VS_ACT_C : ~VS_ACT_C;

`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [15:0] frame_count_r;
   logic        first_seen_r;

   // The first frame_start after reset opens a frame; later ones close one.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count_r <= 16'h0000;
         first_seen_r  <= 1'b0;
      end else if (frame_start) begin
         if (first_seen_r) begin
            frame_count_r <= frame_count_r + 16'h0001;
         end else begin
            frame_count_r <= frame_count_r;
         end
         first_seen_r <= 1'b1;
      end
   end

   assign frame_count = frame_count_r;
`else
   assign frame_count = 16'h0000;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It replaces the fixed 640x480 counter logic embedded in the game top level with a reusable block. It produces pixel coordinates, a blanking-qualified data enable, polarity-configurable sync outputs delayed to match a downstream pixel pipeline, and per-line/per-frame strobes that game logic uses as its update tick. A pixel clock enable allows operation from a faster system clock.

## Interface

Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level
- `CW`, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
- `PIPE`, 1, pixel-enable stages of delay on hs/vs/de (0..8)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset; synchronous, active-high
- `ce` in 1: pixel clock enable; all state advances only when high
- `x` out CW: current column, 0..H_TOTAL-1
- `y` out CW: current line, 0..V_TOTAL-1
- `active` out 1: x<H_VISIBLE && y<V_VISIBLE, undelayed
- `line_start` out 1: one-clk pulse, ce && x==0
- `frame_start` out 1: one-clk pulse, ce && x==0 && y==0
- `vblank_start` out 1: one-clk pulse, ce && x==0 && y==V_VISIBLE
- `de` out 1: `active` delayed PIPE pixels
- `hs` out 1: horizontal sync, delayed PIPE pixels, polarity HS_POL
- `vs` out 1: vertical sync, delayed PIPE pixels, polarity VS_POL
- `frame_count` out 16: completed-frame counter (see Configuration)

## Operation

- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP; V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP.
- Horizontal counter: on ce, x increments; at x==H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only on ce with x==H_TOTAL-1; at y==V_TOTAL-1 it wraps to 0.
- Raw hsync is asserted for x in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC).
- Raw vsync is asserted for y in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC) and spans whole lines, changing only at x==0.
- Delay line: raw hs/vs/active pass through PIPE registers that shift only on ce. PIPE=0 gives combinational passthrough from x/y.
- Output polarity: hs = raw_hs ? HS_POL : ~HS_POL; vs likewise with VS_POL.
- Strobes are combinational from registered x/y and ce. With ce held low they never assert.
- Counter widths: comparisons are unsigned at CW bits. Parameters that overflow CW are a configuration error, and an elaboration-time check must fail on them.

## Timing

- Reset values: x=0, y=0; all delay stages cleared to de=0 and raw sync=0, so hs=~HS_POL and vs=~VS_POL. frame_count=0.
- On the first ce after reset release, frame_start, line_start and active are high. x/y hold (0,0) for that cycle and reach (1,0) on the next clk.
- Latency: hs/vs/de correspond to the x/y values from PIPE ce-cycles earlier. Counted in clk cycles, the latency depends on ce spacing.
- rst asserted mid-frame takes priority over ce. Next clk gives x=y=0 and clears the delay line; there are no partial-frame strobes during reset.
- ce low: x, y, the delay line and frame_count all hold. Outputs stay static.
- Simultaneous wrap: at x==H_TOTAL-1, y==V_TOTAL-1 with ce, both counters go to 0 on the same edge.

## Configuration

- `VGA_TIMING_FRAME_COUNT_EN` defined: frame_count increments on each frame_start except the first after reset, i.e. it counts completed frames. It wraps 0xFFFF->0x0000.
- Not defined: the counter logic is absent and frame_count is tied to 16'h0000.

## Test plan

- Defaults, ce=1: hs low for exactly 96 clks starting at x=656 (PIPE=1 → observed one clk later). Line period is 800 clks; frame_start period is 420000 clks.
- Defaults, ce=1: vs low for exactly 2 lines = 1600 clks beginning at y=490. vblank_start fires once per frame at y=480.
- ce toggling 1,0,1,0: all periods double (line = 1600 clks). x holds during ce=0. No strobe asserts during ce=0 cycles.
- PIPE=3, H_VISIBLE=4, H_FP=1, H_SYNC=2, H_BP=1, HS_POL=1: de rises 3 ce-cycles after x=0, and hs is high 2 clks starting 3 clks after x=5.
- rst asserted at x=300, y=200 for 1 clk: next cycle x=0, y=0, de=0, hs=vs=1 (default polarity). frame_start fires on the following ce.
- With VGA_TIMING_FRAME_COUNT_EN and minimal timing (H_TOTAL=4, V_TOTAL=2): frame_count reads 1 after 16 clks of ce and wraps to 0 after 65536 completed frames. Without the macro it reads 0 throughout.
